// File: rtl/axis_noc_packetizer.sv
// Multi-channel AXI-Stream to NoC injection: packet-granular round-robin arbitration,
// beat-to-flit serialization and credit-based flow control towards the router local port.
module axis_noc_packetizer #(
  parameter int NUM_CHANNELS         = 2,
  parameter int TDATA_WIDTH          = 32,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_BUFFER_DEPTH    = 2,
  parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1),
  localparam int OWNER_WIDTH         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                      clk_noc,
  input  logic                                      rst_noc,
  input  logic [NUM_CHANNELS-1:0]                   axis_in_tvalid,
  output logic [NUM_CHANNELS-1:0]                   axis_in_tready,
  input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]  axis_in_tdata,
  input  logic [NUM_CHANNELS-1:0]                   axis_in_tlast,
  input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]    axis_in_tid,
  input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]  axis_in_tdest,
  output logic [FLIT_WIDTH-1:0]                     data_out,
  output logic [DEST_WIDTH-1:0]                     dest_out,
  output logic                                      is_tail_out,
  output logic                                      send_out,
  input  logic                                      credit_in,
  output logic                                      owner_valid,
  output logic [OWNER_WIDTH-1:0]                    owner_id,
  output logic                                      credit_overflow
);

  localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
  localparam logic [OWNER_WIDTH-1:0]  LAST_CH     = OWNER_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;

  state_t                                           state;
  logic [OWNER_WIDTH-1:0]                           rr_ptr;
  logic                                             beat_valid;
  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0]  beat_data;
  logic                                             beat_last;
  logic [DEST_WIDTH-1:0]                            beat_dest;
  logic [IDX_WIDTH-1:0]                             flit_idx;
  logic [CREDIT_WIDTH-1:0]                          credits;

  logic                   flit_issue;
  logic                   last_flit;
  logic                   beat_done;
  logic                   sel_found;
  logic [OWNER_WIDTH-1:0] sel_ch;
  logic [OWNER_WIDTH-1:0] accept_ch;
  logic [OWNER_WIDTH-1:0] next_rr;
  logic                   accept;
  logic                   accept_last;
  logic [NUM_CHANNELS-1:0] ready_vec;

  assign flit_issue = beat_valid && (credits != '0);
  assign last_flit  = (flit_idx == LAST_IDX);
  assign beat_done  = flit_issue && last_flit;

  // First valid channel at or after the round-robin pointer.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CHANNELS;
      if (!sel_found && axis_in_tvalid[OWNER_WIDTH'(cand)]) begin
        sel_found = 1'b1;
        sel_ch    = OWNER_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    unique case (state)
      IDLE:    if (sel_found) ready_vec[sel_ch] = 1'b1;
      LOCKED:  ready_vec[owner_id] = !beat_valid || beat_done;
      default: ready_vec = '0;
    endcase
  end

  assign axis_in_tready = ready_vec;
  assign accept_ch      = (state == IDLE) ? sel_ch : owner_id;
  assign accept         = axis_in_tvalid[accept_ch] && ready_vec[accept_ch];
  assign accept_last    = axis_in_tlast[accept_ch];
  assign next_rr        = (sel_ch == LAST_CH) ? '0 : sel_ch + OWNER_WIDTH'(1);

  // Ownership is held from the first beat until the tail flit has left.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state       <= IDLE;
      owner_valid <= 1'b0;
      owner_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner_id    <= sel_ch;
            owner_valid <= 1'b1;
            rr_ptr      <= next_rr;
            state       <= accept_last ? DRAIN : LOCKED;
          end
        end
        LOCKED: begin
          if (accept && accept_last) state <= DRAIN;
        end
        DRAIN: begin
          if (beat_done && beat_last) begin
            state       <= IDLE;
            owner_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new beat may load on the same edge the previous beat's last flit leaves.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
      beat_last  <= 1'b0;
      beat_dest  <= '0;
      flit_idx   <= '0;
    end else begin
      if (flit_issue) flit_idx <= last_flit ? '0 : flit_idx + IDX_WIDTH'(1);
      if (accept) begin
        beat_valid <= 1'b1;
        beat_data  <= axis_in_tdata[accept_ch];
        beat_last  <= accept_last;
        beat_dest  <= {axis_in_tid[accept_ch], axis_in_tdest[accept_ch]};
      end else if (beat_done) begin
        beat_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else if (flit_issue) begin
      send_out    <= 1'b1;
      data_out    <= beat_data[flit_idx];
      dest_out    <= beat_dest;
      is_tail_out <= last_flit && beat_last;
    end else begin
      send_out    <= 1'b0;
    end
  end

  // A returned credit with the counter already full is a downstream protocol error.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credits         <= MAX_CREDITS;
      credit_overflow <= 1'b0;
    end else begin
      unique case ({flit_issue, credit_in})
        2'b10: credits <= credits - CREDIT_WIDTH'(1);
        2'b01: begin
          if (credits == MAX_CREDITS) credit_overflow <= 1'b1;
          else                        credits <= credits + CREDIT_WIDTH'(1);
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Randomized bench for axis_noc_packetizer: per-channel packet queues feed a packet-level
// round-robin reference model whose flit stream is compared against the router-side outputs.
module tb_axis_noc_packetizer;

  localparam int NCH    = 2;
  localparam int TDW    = 32;
  localparam int SF     = 2;
  localparam int FW     = TDW / SF;
  localparam int TDESTW = 4;
  localparam int TIDW   = 2;
  localparam int DW     = TDESTW + TIDW;
  localparam int DEPTH  = 2;

  logic                        clk_noc = 1'b0;
  logic                        rst_noc = 1'b1;
  logic [NCH-1:0]              axis_in_tvalid;
  logic [NCH-1:0]              axis_in_tready;
  logic [NCH-1:0][TDW-1:0]     axis_in_tdata;
  logic [NCH-1:0]              axis_in_tlast;
  logic [NCH-1:0][TIDW-1:0]    axis_in_tid;
  logic [NCH-1:0][TDESTW-1:0]  axis_in_tdest;
  logic [FW-1:0]               data_out;
  logic [DW-1:0]               dest_out;
  logic                        is_tail_out;
  logic                        send_out;
  logic                        credit_in;
  logic                        owner_valid;
  logic [0:0]                  owner_id;
  logic                        credit_overflow;

  axis_noc_packetizer #(
    .NUM_CHANNELS(NCH), .TDATA_WIDTH(TDW), .SERIALIZATION_FACTOR(SF),
    .TDEST_WIDTH(TDESTW), .TID_WIDTH(TIDW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in),
    .owner_valid(owner_valid), .owner_id(owner_id), .credit_overflow(credit_overflow)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic [TDW-1:0]    data;
    logic              last;
    logic [TIDW-1:0]   tid;
    logic [TDESTW-1:0] tdest;
  } beat_t;

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
    int            ch;
  } flit_t;

  beat_t drv_q [NCH][$];
  beat_t mdl_q [NCH][$];
  flit_t exp_q [$];
  logic [FW-1:0] sent_log [$];
  int            owner_log [$];

  int       vectors = 0;
  int       miscompares = 0;
  int       rr_model, model_credits, credit_mode, pulses;
  int       flits_seen, run_len, max_run, hs_count;
  bit       gaps_en, exp_overflow;
  bit       pkt_start [NCH];
  logic [NCH-1:0] hs_prev;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic addBeat(input int ch, input logic [TDW-1:0] data, input logic last,
                         input logic [TIDW-1:0] tid, input logic [TDESTW-1:0] tdest);
    beat_t b;
    b.data = data; b.last = last; b.tid = tid; b.tdest = tdest;
    drv_q[ch].push_back(b);
    mdl_q[ch].push_back(b);
  endtask

  task automatic addPacket(input int ch, input int nbeats);
    logic [TIDW-1:0]   tid;
    logic [TDESTW-1:0] tdest;
    tid   = TIDW'($urandom_range(0, 3));
    tdest = TDESTW'($urandom_range(0, 15));
    for (int i = 0; i < nbeats; i++) addBeat(ch, $urandom, i == nbeats - 1, tid, tdest);
  endtask

  // Reference: whole packets granted round-robin among channels with pending packets,
  // each beat split LSB-first into SF flits.
  task automatic buildExpected();
    beat_t b;
    flit_t fl;
    int    ch;
    int    c;
    forever begin
      ch = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (rr_model + k) % NCH;
        if (ch < 0 && mdl_q[c].size() > 0) ch = c;
      end
      if (ch < 0) break;
      do begin
        b = mdl_q[ch].pop_front();
        for (int f = 0; f < SF; f++) begin
          fl.data = FW'(b.data >> (f * FW));
          fl.dest = {b.tid, b.tdest};
          fl.tail = b.last && (f == SF - 1);
          fl.ch   = ch;
          exp_q.push_back(fl);
        end
      end while (!b.last && mdl_q[ch].size() > 0);
      rr_model = (ch + 1) % NCH;
    end
  endtask

  task automatic clearState();
    for (int ch = 0; ch < NCH; ch++) begin
      drv_q[ch].delete();
      mdl_q[ch].delete();
      pkt_start[ch] = 1'b1;
    end
    exp_q.delete();
    hs_prev        = '0;
    axis_in_tvalid = '0;
    credit_in      = 1'b0;
    model_credits  = DEPTH;
    exp_overflow   = 1'b0;
    rr_model       = 0;
    pulses         = 0;
  endtask

  // One clock: retire last edge's handshakes, check outputs, drive the next inputs.
  task automatic tick();
    beat_t b;
    flit_t f;
    @(negedge clk_noc);
    for (int ch = 0; ch < NCH; ch++) begin
      if (hs_prev[ch]) begin
        b = drv_q[ch].pop_front();
        pkt_start[ch] = b.last;
        axis_in_tvalid[ch] = 1'b0;
        hs_count++;
      end
    end
    hs_prev = '0;
    if (send_out) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      flits_seen++;
      checkOutput("credit_avail", 64'(model_credits > 0), 64'd1);
      model_credits--;
      sent_log.push_back(data_out);
      if (is_tail_out) owner_log.push_back(int'(owner_id));
      if (exp_q.size() == 0) begin
        checkOutput("extra_flit", 64'(send_out), 64'd0);
      end else begin
        f = exp_q.pop_front();
        checkOutput("data_out", 64'(data_out), 64'(f.data));
        checkOutput("dest_out", 64'(dest_out), 64'(f.dest));
        checkOutput("is_tail_out", 64'(is_tail_out), 64'(f.tail));
        checkOutput("owner_valid", 64'(owner_valid), 64'(!f.tail));
        checkOutput("owner_id", 64'(owner_id), 64'(f.ch));
      end
    end else begin
      run_len = 0;
    end
    if (credit_in) begin
      if (!send_out && model_credits == DEPTH) exp_overflow = 1'b1;
      else model_credits++;
    end
    checkOutput("credit_overflow", 64'(credit_overflow), 64'(exp_overflow));
    case (credit_mode)
      0: begin
        credit_in = (pulses > 0);
        if (pulses > 0) pulses--;
      end
      1:       credit_in = send_out;
      2:       credit_in = (model_credits < DEPTH) && ($urandom_range(0, 1) == 1);
      default: credit_in = (model_credits < DEPTH);
    endcase
    for (int ch = 0; ch < NCH; ch++) begin
      if (!axis_in_tvalid[ch] && drv_q[ch].size() > 0 &&
          (pkt_start[ch] || !gaps_en || $urandom_range(0, 2) != 0)) begin
        b = drv_q[ch][0];
        axis_in_tvalid[ch] = 1'b1;
        axis_in_tdata[ch]  = b.data;
        axis_in_tlast[ch]  = b.last;
        axis_in_tid[ch]    = b.tid;
        axis_in_tdest[ch]  = b.tdest;
      end
    end
    #1;
    hs_prev = axis_in_tvalid & axis_in_tready;
  endtask

  task automatic applyStimulus(input string tag, input int budget);
    int cyc;
    int pending;
    cyc = 0;
    buildExpected();
    run_len = 0; max_run = 0; hs_count = 0;
    pending = 1;
    while (pending != 0 && cyc < budget) begin
      tick();
      cyc++;
      pending = exp_q.size();
      for (int ch = 0; ch < NCH; ch++) pending += drv_q[ch].size();
    end
    checkOutput({tag, " done"}, 64'(pending), 64'd0);
    repeat (3) tick();
    credit_mode = 3;
    cyc = 0;
    while (model_credits < DEPTH && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput({tag, " credits"}, 64'(model_credits), 64'(DEPTH));
  endtask

  task automatic doReset();
    rst_noc = 1'b1;
    #1;
    checkOutput("rst send_out", 64'(send_out), 64'd0);
    checkOutput("rst is_tail_out", 64'(is_tail_out), 64'd0);
    checkOutput("rst data_out", 64'(data_out), 64'd0);
    checkOutput("rst dest_out", 64'(dest_out), 64'd0);
    checkOutput("rst owner_valid", 64'(owner_valid), 64'd0);
    checkOutput("rst owner_id", 64'(owner_id), 64'd0);
    checkOutput("rst credit_overflow", 64'(credit_overflow), 64'd0);
    clearState();
    repeat (2) @(negedge clk_noc);
    rst_noc = 1'b0;
  endtask

  initial begin
    int cyc;
    axis_in_tvalid = '0;
    axis_in_tdata  = '0;
    axis_in_tlast  = '0;
    axis_in_tid    = '0;
    axis_in_tdest  = '0;
    credit_in      = 1'b0;
    credit_mode    = 1;
    gaps_en        = 1'b0;
    clearState();
    repeat (2) @(negedge clk_noc);
    doReset();

    $display("[TB] single beat");
    credit_mode = 1;
    sent_log.delete();
    addBeat(0, 32'hDEADBEEF, 1'b1, 2'd1, 4'd5);
    applyStimulus("single", 40);
    checkOutput("single count", 64'(sent_log.size()), 64'd2);
    checkOutput("single flit0", 64'(sent_log[0]), 64'hBEEF);
    checkOutput("single flit1", 64'(sent_log[1]), 64'hDEAD);
    checkOutput("single owner drop", 64'(owner_valid), 64'd0);

    $display("[TB] credit stall");
    credit_mode = 0;
    flits_seen  = 0;
    addPacket(0, 2);
    buildExpected();
    repeat (10) tick();
    checkOutput("stall count", 64'(flits_seen), 64'd2);
    checkOutput("stall send_out", 64'(send_out), 64'd0);
    pulses = 1;
    repeat (10) tick();
    checkOutput("pulse count", 64'(flits_seen), 64'd3);
    checkOutput("pulse send_out", 64'(send_out), 64'd0);
    credit_mode = 3;
    applyStimulus("stall finish", 60);

    $display("[TB] back-to-back throughput");
    credit_mode = 1;
    gaps_en     = 1'b0;
    addPacket(1, 4);
    applyStimulus("thru", 60);
    checkOutput("thru run", 64'(max_run), 64'd8);
    checkOutput("thru handshakes", 64'(hs_count), 64'd4);

    $display("[TB] arbitration fairness");
    doReset();
    credit_mode = 2;
    gaps_en     = 1'b1;
    owner_log.delete();
    addPacket(0, 3); addPacket(1, 3); addPacket(0, 3); addPacket(1, 3);
    applyStimulus("fair", 300);
    checkOutput("fair packets", 64'(owner_log.size()), 64'd4);
    checkOutput("fair pkt0", 64'(owner_log[0]), 64'd0);
    checkOutput("fair pkt1", 64'(owner_log[1]), 64'd1);
    checkOutput("fair pkt2", 64'(owner_log[2]), 64'd0);
    checkOutput("fair pkt3", 64'(owner_log[3]), 64'd1);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 6; r++) begin
      credit_mode = 2;
      gaps_en     = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) addPacket(ch, $urandom_range(1, 4));
      end
      applyStimulus("rand", 600);
    end

    $display("[TB] credit overflow");
    doReset();
    credit_mode = 0;
    pulses      = 1;
    repeat (4) tick();
    checkOutput("ovf set", 64'(credit_overflow), 64'd1);
    flits_seen = 0;
    addPacket(0, 2);
    buildExpected();
    repeat (10) tick();
    checkOutput("ovf credit cap", 64'(flits_seen), 64'd2);
    credit_mode = 3;
    applyStimulus("ovf finish", 60);
    checkOutput("ovf sticky", 64'(credit_overflow), 64'd1);

    $display("[TB] reset mid-packet");
    doReset();
    credit_mode = 1;
    flits_seen  = 0;
    addBeat(0, 32'hA5A55A5A, 1'b1, 2'd2, 4'd3);
    buildExpected();
    cyc = 0;
    while (flits_seen < 1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("mid flit0 seen", 64'(flits_seen), 64'd1);
    doReset();
    credit_mode = 0;
    flits_seen  = 0;
    sent_log.delete();
    addBeat(0, 32'hCAFE1234, 1'b0, 2'd3, 4'd9);
    addBeat(0, 32'h0BADF00D, 1'b1, 2'd3, 4'd9);
    buildExpected();
    repeat (10) tick();
    checkOutput("post rst credits", 64'(flits_seen), 64'd2);
    checkOutput("post rst flit0", 64'(sent_log[0]), 64'h1234);
    credit_mode = 3;
    applyStimulus("post rst finish", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
